tlb_cp0_ctrl: RTL and testbench
===============================

# tlb_cp0_ctrl

CP0-side controller that executes the four MIPS TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the dual-search-port TLB. It holds the CP0 TLB registers: Index, EntryHi, EntryLo0, EntryLo1, Random and Wired. It drives the TLB's write port, read port and search port 1, and sits between the exception/CP0 stage and the TLB array. Each instruction is accepted through a valid/ready handshake and completes in a fixed two-cycle sequence.

## Interface
- TLBNUM, 16, TLB entry count; IDXW = $clog2(TLBNUM)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- op_valid  in  1  TLB instruction request
- op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready  out  1  high only in IDLE
- op_done  out  1  one-cycle pulse in the cycle after acceptance
- mtc0_we  in  1  CP0 register write strobe
- mtc0_sel  in  3  0 Index, 1 EntryHi, 2 EntryLo0, 3 EntryLo1, 4 Wired; others ignored
- mtc0_wdata  in  32  write data
- index_o, entryhi_o, entrylo0_o, entrylo1_o, random_o, wired_o  out  32 each  register contents
- tlb_we  out  1  TLB write enable
- tlb_w_index  out  IDXW  write slot
- tlb_w_vpn2  out  19
- tlb_w_asid  out  8
- tlb_w_g  out  1
- tlb_w_pfn0 / tlb_w_pfn1  out  20 each
- tlb_w_c0 / tlb_w_c1  out  3 each
- tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1  out  1 each
- tlb_r_index  out  IDXW  read slot
- tlb_r_vpn2, tlb_r_asid, tlb_r_g, tlb_r_pfn0/1, tlb_r_c0/1, tlb_r_d0/1, tlb_r_v0/1  in  same widths as write fields
- tlb_s1_vpn2  out  19  driven as EntryHi[31:13]
- tlb_s1_odd_page  out  1  constant 0
- tlb_s1_asid  out  8  driven as EntryHi[7:0]
- tlb_s1_found  in  1  search hit
- tlb_s1_index  in  IDXW  matching slot

## Operation
- Register formats:
  - EntryHi: VPN2 [31:13], ASID [7:0].
  - EntryLo: PFN [25:6], C [5:3], D [2], V [1], G [0].
  - Index: P [31], index [IDXW-1:0].
  - Unlisted bits read 0.
- Writable masks:
  - Index: index bits only; P is read-only.
  - EntryHi: [31:13] and [7:0].
  - EntryLo: [25:0].
  - Wired: [IDXW-1:0].
  - Random: read-only.
- FSM states: IDLE, PROBE, READ, WRITE.
  - IDLE→X on op_valid: TLBP→PROBE, TLBR→READ, TLBWI/TLBWR→WRITE.
  - Every non-IDLE state returns to IDLE after one cycle and asserts op_done in that cycle.
- PROBE:
  - Search port is driven from EntryHi.
  - At the edge: Index.P = ~tlb_s1_found; index = tlb_s1_found ? tlb_s1_index : 0.
- READ:
  - tlb_r_index = Index.index.
  - At the edge: EntryHi ← {vpn2, 5'b0, asid}.
  - EntryLo0/1 ← {pfn, c, d, v, g}, with g = tlb_r_g in both.
- WRITE:
  - tlb_we = 1 for exactly this cycle.
  - Fields are taken from EntryHi/EntryLo0/EntryLo1; tlb_w_g = EntryLo0.G & EntryLo1.G.
  - tlb_w_index = Index.index for TLBWI, or the Random value latched at acceptance for TLBWR.
- Random:
  - Reset value TLBNUM-1; decrements every cycle.
  - When current value ≤ Wired (including 0), the next value is TLBNUM-1.
  - Any mtc0 write to Wired sets Random to TLBNUM-1 at the same edge.
- Same-edge mtc0 and op result on the same register: the op result wins.
- An mtc0 in the acceptance cycle is visible to the following WRITE.

## Timing
- Reset values:
  - All registers 0, except Random = TLBNUM-1.
  - State IDLE; op_ready = 1; op_done = 0; tlb_we = 0.
  - tlb_w_* and tlb_r_index = 0.
- Latency and throughput:
  - Acceptance at edge N. op_done and tlb_we are high during cycle N+1.
  - Register updates are visible from N+2.
  - Maximum throughput is one op every 2 cycles.
- Reset asserted mid-op: IDLE at the next edge, no tlb_we, no op_done, no register update from the aborted op.
- op_valid while op_ready=0 is not accepted; the requester holds it.

## Structure
- tlb_pkg holds:
  - op_code enum and mtc0_sel constants;
  - EntryLo/EntryHi field bit positions;
  - the FSM state enum.
- Sub-module tlb_random_ctr: Random counter, with Wired and wired_write inputs.

## Test plan
- Reset, then idle 3 cycles → random_o = 15, 14, 13; index_o = 0; op_ready = 1.
- Write Wired = 4, let Random count down → Random is 15 at the write edge; after reaching 4 it wraps to 15; it never holds a value < 4.
- Load EntryHi = 0x0000_2005, EntryLo0 = 0x41, EntryLo1 = 0x83, Index = 3, then TLBWI →
  - one tlb_we pulse with w_index = 3, vpn2 = 1, asid = 5, pfn0 = 1, pfn1 = 2, g = 1;
  - op_done in the same cycle.
- TLBP with the same EntryHi after that write → index_o = 0x0000_0003. With ASID changed to 6 and G = 0 entries only → index_o = 0x8000_0000.
- TLBR of slot 3 → entrylo0_o = 0x41, entrylo1_o = 0x83, entryhi_o = 0x0000_2005.
- TLBWR issued when random_o = 9 → tlb_w_index = 9. Reset asserted during a WRITE cycle → at the next edge: IDLE, no op_done.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0 TLB controller: op codes, CP0 select codes,
// register field positions and the sequencer state encoding.
package tlb_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } op_code_e;

  localparam logic [2:0] SEL_INDEX    = 3'd0;
  localparam logic [2:0] SEL_ENTRYHI  = 3'd1;
  localparam logic [2:0] SEL_ENTRYLO0 = 3'd2;
  localparam logic [2:0] SEL_ENTRYLO1 = 3'd3;
  localparam logic [2:0] SEL_WIRED    = 3'd4;

  localparam int HI_VPN2_MSB = 31;
  localparam int HI_VPN2_LSB = 13;
  localparam int HI_ASID_MSB = 7;
  localparam int HI_ASID_LSB = 0;

  localparam int LO_PFN_MSB = 25;
  localparam int LO_PFN_LSB = 6;
  localparam int LO_C_MSB   = 5;
  localparam int LO_C_LSB   = 3;
  localparam int LO_D       = 2;
  localparam int LO_V       = 1;
  localparam int LO_G       = 0;

  localparam int INDEX_P = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_READ,
    ST_WRITE
  } state_e;

  function automatic logic [31:0] pack_entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                               input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_cp0_ctrl_random.sv
// CP0 Random register: free-running down-counter that never drops below Wired.
module tlb_random_ctr
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] wired,
  input  logic            wired_write,
  output logic [IDXW-1:0] random
);

  localparam logic [IDXW-1:0] RANDOM_TOP = IDXW'(TLBNUM - 1);

  // Reaching Wired (or 0 when Wired is 0) reloads instead of decrementing.
  always_ff @(posedge clk) begin
    if (rst) begin
      random <= RANDOM_TOP;
    end else if (wired_write || (random <= wired)) begin
      random <= RANDOM_TOP;
    end else begin
      random <= random - 1'b1;
    end
  end

endmodule

// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB registers plus the two-cycle TLBP/TLBR/TLBWI/TLBWR sequencer.
// state | meaning: IDLE ready | PROBE Index<-search | READ Entry*<-TLB | WRITE tlb_we high
module tlb_cp0_ctrl
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [1:0]      op_code,
  output logic            op_ready,
  output logic            op_done,
  input  logic            mtc0_we,
  input  logic [2:0]      mtc0_sel,
  input  logic [31:0]     mtc0_wdata,
  output logic [31:0]     index_o,
  output logic [31:0]     entryhi_o,
  output logic [31:0]     entrylo0_o,
  output logic [31:0]     entrylo1_o,
  output logic [31:0]     random_o,
  output logic [31:0]     wired_o,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [18:0]     tlb_w_vpn2,
  output logic [7:0]      tlb_w_asid,
  output logic            tlb_w_g,
  output logic [19:0]     tlb_w_pfn0,
  output logic [19:0]     tlb_w_pfn1,
  output logic [2:0]      tlb_w_c0,
  output logic [2:0]      tlb_w_c1,
  output logic            tlb_w_d0,
  output logic            tlb_w_v0,
  output logic            tlb_w_d1,
  output logic            tlb_w_v1,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [18:0]     tlb_r_vpn2,
  input  logic [7:0]      tlb_r_asid,
  input  logic            tlb_r_g,
  input  logic [19:0]     tlb_r_pfn0,
  input  logic [19:0]     tlb_r_pfn1,
  input  logic [2:0]      tlb_r_c0,
  input  logic [2:0]      tlb_r_c1,
  input  logic            tlb_r_d0,
  input  logic            tlb_r_v0,
  input  logic            tlb_r_d1,
  input  logic            tlb_r_v1,
  output logic [18:0]     tlb_s1_vpn2,
  output logic            tlb_s1_odd_page,
  output logic [7:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index
);

  state_e          state;
  logic            wr_use_random;
  logic [IDXW-1:0] wr_random_slot;
  logic [IDXW-1:0] random_q;
  logic            index_p;
  logic [IDXW-1:0] index_idx;
  logic [31:0]     entryhi;
  logic [31:0]     entrylo0;
  logic [31:0]     entrylo1;
  logic [IDXW-1:0] wired;
  logic            unused_wdata;

  assign unused_wdata = ^mtc0_wdata[12:8];

  tlb_random_ctr #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_random (
    .clk        (clk),
    .rst        (rst),
    .wired      (wired),
    .wired_write(mtc0_we && (mtc0_sel == SEL_WIRED)),
    .random     (random_q)
  );

  // Random is sampled at acceptance so a TLBWR targets the slot seen when issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_ready       <= 1'b1;
      op_done        <= 1'b0;
      tlb_we         <= 1'b0;
      wr_use_random  <= 1'b0;
      wr_random_slot <= '0;
    end else begin
      op_done <= 1'b0;
      tlb_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_ready       <= 1'b0;
            op_done        <= 1'b1;
            wr_use_random  <= (op_code_e'(op_code) == OP_TLBWR);
            wr_random_slot <= random_q;
            case (op_code_e'(op_code))
              OP_TLBP: state <= ST_PROBE;
              OP_TLBR: state <= ST_READ;
              default: begin
                state  <= ST_WRITE;
                tlb_we <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

  // Op results are assigned after mtc0 so they win on a same-edge collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_p   <= 1'b0;
      index_idx <= '0;
      entryhi   <= '0;
      entrylo0  <= '0;
      entrylo1  <= '0;
      wired     <= '0;
    end else begin
      if (mtc0_we) begin
        case (mtc0_sel)
          SEL_INDEX:    index_idx <= mtc0_wdata[IDXW-1:0];
          SEL_ENTRYHI:  entryhi   <= {mtc0_wdata[HI_VPN2_MSB:HI_VPN2_LSB], 5'b0,
                                      mtc0_wdata[HI_ASID_MSB:HI_ASID_LSB]};
          SEL_ENTRYLO0: entrylo0  <= {6'b0, mtc0_wdata[LO_PFN_MSB:0]};
          SEL_ENTRYLO1: entrylo1  <= {6'b0, mtc0_wdata[LO_PFN_MSB:0]};
          SEL_WIRED:    wired     <= mtc0_wdata[IDXW-1:0];
          default: ;
        endcase
      end
      if (state == ST_PROBE) begin
        index_p   <= ~tlb_s1_found;
        index_idx <= tlb_s1_found ? tlb_s1_index : '0;
      end
      if (state == ST_READ) begin
        entryhi  <= {tlb_r_vpn2, 5'b0, tlb_r_asid};
        entrylo0 <= pack_entrylo(tlb_r_pfn0, tlb_r_c0, tlb_r_d0, tlb_r_v0, tlb_r_g);
        entrylo1 <= pack_entrylo(tlb_r_pfn1, tlb_r_c1, tlb_r_d1, tlb_r_v1, tlb_r_g);
      end
    end
  end

  always_comb begin
    tlb_w_index = '0;
    tlb_w_vpn2  = '0;
    tlb_w_asid  = '0;
    tlb_w_g     = 1'b0;
    tlb_w_pfn0  = '0;
    tlb_w_pfn1  = '0;
    tlb_w_c0    = '0;
    tlb_w_c1    = '0;
    tlb_w_d0    = 1'b0;
    tlb_w_v0    = 1'b0;
    tlb_w_d1    = 1'b0;
    tlb_w_v1    = 1'b0;
    if (tlb_we) begin
      tlb_w_index = wr_use_random ? wr_random_slot : index_idx;
      tlb_w_vpn2  = entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
      tlb_w_asid  = entryhi[HI_ASID_MSB:HI_ASID_LSB];
      tlb_w_g     = entrylo0[LO_G] & entrylo1[LO_G];
      tlb_w_pfn0  = entrylo0[LO_PFN_MSB:LO_PFN_LSB];
      tlb_w_pfn1  = entrylo1[LO_PFN_MSB:LO_PFN_LSB];
      tlb_w_c0    = entrylo0[LO_C_MSB:LO_C_LSB];
      tlb_w_c1    = entrylo1[LO_C_MSB:LO_C_LSB];
      tlb_w_d0    = entrylo0[LO_D];
      tlb_w_v0    = entrylo0[LO_V];
      tlb_w_d1    = entrylo1[LO_D];
      tlb_w_v1    = entrylo1[LO_V];
    end
  end

  assign tlb_r_index     = (state == ST_READ) ? index_idx : '0;
  assign tlb_s1_vpn2     = entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
  assign tlb_s1_asid     = entryhi[HI_ASID_MSB:HI_ASID_LSB];
  assign tlb_s1_odd_page = 1'b0;

  assign index_o    = {index_p, {(INDEX_P - IDXW){1'b0}}, index_idx};
  assign entryhi_o  = entryhi;
  assign entrylo0_o = entrylo0;
  assign entrylo1_o = entrylo1;
  assign random_o   = {{(32 - IDXW){1'b0}}, random_q};
  assign wired_o    = {{(32 - IDXW){1'b0}}, wired};

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Bench for tlb_cp0_ctrl: behavioural CP0/TLB model checked every cycle, plus directed scenarios.
module tb_tlb_cp0_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            op_valid = 1'b0;
  logic [1:0]      op_code = 2'b00;
  logic            op_ready, op_done;
  logic            mtc0_we = 1'b0;
  logic [2:0]      mtc0_sel = 3'd0;
  logic [31:0]     mtc0_wdata = 32'd0;
  logic [31:0]     index_o, entryhi_o, entrylo0_o, entrylo1_o, random_o, wired_o;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index, tlb_r_index, tlb_s1_index;
  logic [18:0]     tlb_w_vpn2, tlb_r_vpn2, tlb_s1_vpn2;
  logic [7:0]      tlb_w_asid, tlb_r_asid, tlb_s1_asid;
  logic            tlb_w_g, tlb_r_g;
  logic [19:0]     tlb_w_pfn0, tlb_w_pfn1, tlb_r_pfn0, tlb_r_pfn1;
  logic [2:0]      tlb_w_c0, tlb_w_c1, tlb_r_c0, tlb_r_c1;
  logic            tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic            tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic            tlb_s1_odd_page, tlb_s1_found;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_cp0_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done),
    .mtc0_we(mtc0_we), .mtc0_sel(mtc0_sel), .mtc0_wdata(mtc0_wdata),
    .index_o(index_o), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
    .entrylo1_o(entrylo1_o), .random_o(random_o), .wired_o(wired_o),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_vpn2(tlb_w_vpn2),
    .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g), .tlb_w_pfn0(tlb_w_pfn0),
    .tlb_w_pfn1(tlb_w_pfn1), .tlb_w_c0(tlb_w_c0), .tlb_w_c1(tlb_w_c1),
    .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0), .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
    .tlb_r_index(tlb_r_index), .tlb_r_vpn2(tlb_r_vpn2), .tlb_r_asid(tlb_r_asid),
    .tlb_r_g(tlb_r_g), .tlb_r_pfn0(tlb_r_pfn0), .tlb_r_pfn1(tlb_r_pfn1),
    .tlb_r_c0(tlb_r_c0), .tlb_r_c1(tlb_r_c1), .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
    .tlb_s1_vpn2(tlb_s1_vpn2), .tlb_s1_odd_page(tlb_s1_odd_page),
    .tlb_s1_asid(tlb_s1_asid), .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- TLB array seen by the controller ----------------
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0, v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1, v1;
  } ent_t;

  ent_t mem [TLBNUM];
  ent_t rd_e;
  bit   mem_ready = 1'b0;

  function automatic bit hit(input ent_t e, input logic [18:0] vpn2, input logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  // Initial contents use VPN2 values with bit 18 set so directed probes do not collide.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < TLBNUM; i++)
        mem[i] <= {1'b1, 18'($urandom), 8'($urandom), 1'($urandom), 20'($urandom), 3'($urandom),
                   2'($urandom), 20'($urandom), 3'($urandom), 2'($urandom)};
      mem_ready <= 1'b1;
    end else if (tlb_we) begin
      mem[tlb_w_index] <= {tlb_w_vpn2, tlb_w_asid, tlb_w_g, tlb_w_pfn0, tlb_w_c0, tlb_w_d0,
                           tlb_w_v0, tlb_w_pfn1, tlb_w_c1, tlb_w_d1, tlb_w_v1};
    end
  end

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit(mem[i], tlb_s1_vpn2, tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  always_comb rd_e = mem[tlb_r_index];
  assign tlb_r_vpn2 = rd_e.vpn2;
  assign tlb_r_asid = rd_e.asid;
  assign tlb_r_g    = rd_e.g;
  assign tlb_r_pfn0 = rd_e.pfn0;
  assign tlb_r_c0   = rd_e.c0;
  assign tlb_r_d0   = rd_e.d0;
  assign tlb_r_v0   = rd_e.v0;
  assign tlb_r_pfn1 = rd_e.pfn1;
  assign tlb_r_c1   = rd_e.c1;
  assign tlb_r_d1   = rd_e.d1;
  assign tlb_r_v1   = rd_e.v1;

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  bit          m_busy;
  logic [1:0]  m_op;
  logic        m_p;
  logic [3:0]  m_idx, m_wired, m_random, m_slot;
  logic [31:0] m_hi, m_lo0, m_lo1;
  bit          mt_found, mt_busy;
  logic [3:0]  mt_fidx, mt_rand;
  logic [1:0]  mt_op;
  ent_t        mt_e;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_op = 2'd0; m_p = 1'b0; m_idx = 4'd0;
      m_wired = 4'd0; m_random = 4'd15; m_slot = 4'd0;
      m_hi = 32'd0; m_lo0 = 32'd0; m_lo1 = 32'd0;
    end else if (m_valid) begin
      mt_rand = m_random;
      if ((mtc0_we && mtc0_sel == 3'd4) || m_random <= m_wired) m_random = 4'd15;
      else m_random = m_random - 4'd1;
      mt_found = 1'b0;
      mt_fidx  = 4'd0;
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (hit(mem[i], m_hi[31:13], m_hi[7:0])) begin
          mt_found = 1'b1;
          mt_fidx  = 4'(i);
        end
      mt_e    = mem[m_idx];
      mt_busy = m_busy;
      mt_op   = m_op;
      if (mtc0_we) begin
        case (mtc0_sel)
          3'd0: m_idx   = mtc0_wdata[3:0];
          3'd1: m_hi    = mtc0_wdata & 32'hFFFF_E0FF;
          3'd2: m_lo0   = mtc0_wdata & 32'h03FF_FFFF;
          3'd3: m_lo1   = mtc0_wdata & 32'h03FF_FFFF;
          3'd4: m_wired = mtc0_wdata[3:0];
          default: ;
        endcase
      end
      if (mt_busy) begin
        if (mt_op == 2'd0) begin
          m_p   = !mt_found;
          m_idx = mt_found ? mt_fidx : 4'd0;
        end else if (mt_op == 2'd1) begin
          m_hi  = {mt_e.vpn2, 5'b0, mt_e.asid};
          m_lo0 = {6'b0, mt_e.pfn0, mt_e.c0, mt_e.d0, mt_e.v0, mt_e.g};
          m_lo1 = {6'b0, mt_e.pfn1, mt_e.c1, mt_e.d1, mt_e.v1, mt_e.g};
        end
        m_busy = 1'b0;
      end else if (op_valid) begin
        m_busy = 1'b1;
        m_op   = op_code;
        m_slot = mt_rand;
      end
    end
  end

  bit e_we;
  always @(negedge clk) begin
    if (m_valid) begin
      e_we = m_busy && m_op[1];
      chk("op_ready", 32'(op_ready), 32'(!m_busy));
      chk("op_done", 32'(op_done), 32'(m_busy));
      chk("tlb_we", 32'(tlb_we), 32'(e_we));
      chk("w_index", 32'(tlb_w_index), !e_we ? 32'd0 : (m_op == 2'd3 ? 32'(m_slot) : 32'(m_idx)));
      chk("w_vpn2", 32'(tlb_w_vpn2), e_we ? 32'(m_hi[31:13]) : 32'd0);
      chk("w_asid", 32'(tlb_w_asid), e_we ? 32'(m_hi[7:0]) : 32'd0);
      chk("w_g", 32'(tlb_w_g), e_we ? 32'(m_lo0[0] & m_lo1[0]) : 32'd0);
      chk("w_pfn0", 32'(tlb_w_pfn0), e_we ? 32'(m_lo0[25:6]) : 32'd0);
      chk("w_pfn1", 32'(tlb_w_pfn1), e_we ? 32'(m_lo1[25:6]) : 32'd0);
      chk("w_flags", 32'({tlb_w_c0, tlb_w_d0, tlb_w_v0, tlb_w_c1, tlb_w_d1, tlb_w_v1}),
          e_we ? 32'({m_lo0[5:1], m_lo1[5:1]}) : 32'd0);
      chk("r_index", 32'(tlb_r_index), (m_busy && m_op == 2'd1) ? 32'(m_idx) : 32'd0);
      chk("s1_vpn2", 32'(tlb_s1_vpn2), 32'(m_hi[31:13]));
      chk("s1_asid", 32'(tlb_s1_asid), 32'(m_hi[7:0]));
      chk("s1_odd", 32'(tlb_s1_odd_page), 32'd0);
      chk("index_o", index_o, {m_p, 27'd0, m_idx});
      chk("entryhi_o", entryhi_o, m_hi);
      chk("entrylo0_o", entrylo0_o, m_lo0);
      chk("entrylo1_o", entrylo1_o, m_lo1);
      chk("random_o", random_o, 32'(m_random));
      chk("wired_o", wired_o, 32'(m_wired));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [2:0] sel, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_sel = sel; mtc0_wdata = d;
    tick();
    mtc0_we = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] code);
    op_valid = 1'b1; op_code = code;
    tick();
    op_valid = 1'b0;
    tick();
  endtask

  logic [31:0] prev_r, min_r;
  bit          seen_wrap, got9;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_random", random_o, 32'd15);
    chk("rst_index", index_o, 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_we", 32'(tlb_we), 32'd0);
    tick(); chk("idle_random1", random_o, 32'd14);
    tick(); chk("idle_random2", random_o, 32'd13);

    mtc0(3'd4, 32'd4);
    chk("wired_write_random", random_o, 32'd15);
    min_r = 32'd15; seen_wrap = 1'b0; prev_r = random_o;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (random_o < min_r) min_r = random_o;
      if (prev_r == 32'd4 && random_o == 32'd15) seen_wrap = 1'b1;
      prev_r = random_o;
    end
    chk("random_min", min_r, 32'd4);
    chk("random_wrap", 32'(seen_wrap), 32'd1);

    mtc0(3'd1, 32'h0000_2005);
    mtc0(3'd2, 32'h41);
    mtc0(3'd3, 32'h83);
    mtc0(3'd0, 32'd3);
    op_valid = 1'b1; op_code = 2'b10;
    tick();
    op_valid = 1'b0;
    chk("wi_we", 32'(tlb_we), 32'd1);
    chk("wi_done", 32'(op_done), 32'd1);
    chk("wi_index", 32'(tlb_w_index), 32'd3);
    chk("wi_vpn2", 32'(tlb_w_vpn2), 32'd1);
    chk("wi_asid", 32'(tlb_w_asid), 32'd5);
    chk("wi_pfn0", 32'(tlb_w_pfn0), 32'd1);
    chk("wi_pfn1", 32'(tlb_w_pfn1), 32'd2);
    chk("wi_g", 32'(tlb_w_g), 32'd1);
    tick();
    chk("wi_we_one_cycle", 32'(tlb_we), 32'd0);

    do_op(2'b00);
    chk("probe_hit", index_o, 32'h0000_0003);

    mtc0(3'd2, 32'h40);
    mtc0(3'd3, 32'h82);
    do_op(2'b10);
    mtc0(3'd1, 32'h0000_2006);
    do_op(2'b00);
    chk("probe_miss", index_o, 32'h8000_0000);

    mtc0(3'd0, 32'd3);
    mtc0(3'd1, 32'h0000_2005);
    mtc0(3'd2, 32'h41);
    mtc0(3'd3, 32'h83);
    do_op(2'b10);
    mtc0(3'd1, 32'd0);
    mtc0(3'd2, 32'd0);
    mtc0(3'd3, 32'd0);
    do_op(2'b01);
    chk("tlbr_lo0", entrylo0_o, 32'h41);
    chk("tlbr_lo1", entrylo1_o, 32'h83);
    chk("tlbr_hi", entryhi_o, 32'h0000_2005);

    got9 = 1'b0;
    for (int i = 0; i < 40 && !got9; i++) begin
      if (random_o == 32'd9) got9 = 1'b1;
      else tick();
    end
    chk("wait_random9", 32'(got9), 32'd1);
    if (got9) begin
      op_valid = 1'b1; op_code = 2'b11;
      tick();
      op_valid = 1'b0;
      chk("wr_we", 32'(tlb_we), 32'd1);
      chk("wr_index", 32'(tlb_w_index), 32'd9);
      tick();
    end

    op_valid = 1'b1; op_code = 2'b10;
    tick();
    op_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_done", 32'(op_done), 32'd0);
    chk("abort_we", 32'(tlb_we), 32'd0);
    chk("abort_ready", 32'(op_ready), 32'd1);

    for (int i = 0; i < 600; i++) begin
      op_valid   = ($urandom_range(0, 2) == 0);
      op_code    = 2'($urandom);
      mtc0_we    = ($urandom_range(0, 3) == 0);
      mtc0_sel   = 3'($urandom);
      mtc0_wdata = $urandom;
      rst        = ($urandom_range(0, 96) == 0);
      tick();
    end
    op_valid = 1'b0; mtc0_we = 1'b0; rst = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
